// File: rtl/alu_32_if.sv
// Operand/opcode and result/flag bundle for the execute-stage ALU.
// The master drives operands; the slave (the ALU) drives the registered results.
interface alu_32_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUControl;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;

  modport master (output A, B, ALUControl, input  Result, Zero, Overflow);
  modport slave  (input  A, B, ALUControl, output Result, Zero, Overflow);
endinterface

// File: rtl/alu_32.sv
// 32-bit registered ALU: one op per cycle, outputs valid one edge after sampling.
// ADD/SUB/SLT/SLTU share a single adder; SUB is formed as A + ~B + 1.
module alu_32 (
  input  logic     clk,
  input  logic     rst,
  alu_32_if.slave  bus
);
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_NOR  = 3'b110,
    OP_SLTU = 3'b111
  } alu_op_e;

  alu_op_e     op;
  logic        sub_sel;
  logic [31:0] b_opnd;
  logic [31:0] sum;
  logic        carry;
  logic        ovf_add;
  logic        ovf_sub;
  logic        slt_less;
  logic        sltu_less;

  logic [31:0] result_d, result_q;
  logic        zero_d,   zero_q;
  logic        ovf_d,    ovf_q;

  assign op = alu_op_e'(bus.ALUControl);

  // Everything except ADD needs the difference (SLT/SLTU compare through it).
  always_comb begin
    sub_sel      = (op != OP_ADD);
    b_opnd       = sub_sel ? ~bus.B : bus.B;
    {carry, sum} = {1'b0, bus.A} + {1'b0, b_opnd} + {32'd0, sub_sel};
    ovf_add      = (bus.A[31] == bus.B[31]) && (sum[31] != bus.A[31]);
    ovf_sub      = (bus.A[31] != bus.B[31]) && (sum[31] != bus.A[31]);
    // Sign of the difference is wrong exactly when it overflowed.
    slt_less     = sum[31] ^ ovf_sub;
    // No carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned.
    sltu_less    = ~carry;
  end

  always_comb begin
    result_d = 32'd0;
    ovf_d    = 1'b0;
    unique case (op)
      OP_ADD:  begin result_d = sum; ovf_d = ovf_add; end
      OP_SUB:  begin result_d = sum; ovf_d = ovf_sub; end
      OP_AND:  result_d = bus.A & bus.B;
      OP_OR:   result_d = bus.A | bus.B;
      OP_XOR:  result_d = bus.A ^ bus.B;
      OP_SLT:  result_d = {31'd0, slt_less};
      OP_NOR:  result_d = ~(bus.A | bus.B);
      OP_SLTU: result_d = {31'd0, sltu_less};
      default: result_d = 32'd0;
    endcase
    zero_d = (result_d == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 32'd0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.Result   = result_q;
  assign bus.Zero     = zero_q;
  assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_alu_32.sv
// Bench for alu_32: directed vector table, reset/back-to-back sequences,
// and randomized ops against an arithmetic reference model.
module tb_alu_32;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_32_if bif ();

  alu_32 dut (.clk(clk), .rst(rst), .bus(bif));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, logic z, logic ov);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.res = res; v.z = z; v.ov = ov;
    return v;
  endfunction

  // Reference: signed results computed in 64-bit and range-checked against 32 bits.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z, output logic v);
    longint sa, sb, s, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = 64'sd2147483648;
    s   = 0;
    v   = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; r = s[31:0]; v = (s >= lim) || (s < -lim); end
      3'd1: begin s = sa - sb; r = s[31:0]; v = (s >= lim) || (s < -lim); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r = ~(a | b);
      default: r = (a < b) ? 32'd1 : 32'd0;
    endcase
    z = (r == 32'd0);
  endfunction

  task automatic check(string name, logic [31:0] er, logic ez, logic eo);
    checks++;
    if (bif.Result !== er || bif.Zero !== ez || bif.Overflow !== eo) begin
      errors++;
      $display("FAIL %s: got R=%h Z=%b V=%b, expected R=%h Z=%b V=%b",
               name, bif.Result, bif.Zero, bif.Overflow, er, ez, eo);
    end
  endtask

  // Drive on the falling edge, return just after the next rising edge.
  task automatic step(logic r, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    rst = r; bif.ALUControl = op; bif.A = a; bif.B = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] er, pr;
    logic        ez, eo, pz, po;
    logic [2:0]  op;
    logic [31:0] a, b;

    vecs.push_back(mk("add",        3'd0, 32'h1234,     32'h4321,     32'h0000_5555, 0, 0));
    vecs.push_back(mk("sub",        3'd1, 32'hF000,     32'h1234,     32'h0000_DDCC, 0, 0));
    vecs.push_back(mk("and",        3'd2, 32'hAAAA,     32'hCCCC,     32'h0000_8888, 0, 0));
    vecs.push_back(mk("or",         3'd3, 32'h1130,     32'h0204,     32'h0000_1334, 0, 0));
    vecs.push_back(mk("xor",        3'd4, 32'hAAAA,     32'hCCCC,     32'h0000_6666, 0, 0));
    vecs.push_back(mk("nor",        3'd6, 32'h0,        32'h0,        32'hFFFF_FFFF, 0, 0));
    vecs.push_back(mk("sub_zero",   3'd1, 32'h8000,     32'h8000,     32'h0,         1, 0));
    vecs.push_back(mk("slt_5_10",   3'd5, 32'd5,        32'd10,       32'd1,         0, 0));
    vecs.push_back(mk("slt_20_10",  3'd5, 32'd20,       32'd10,       32'd0,         1, 0));
    vecs.push_back(mk("slt_m50_5",  3'd5, 32'hFFFF_FFCE, 32'd5,       32'd1,         0, 0));
    vecs.push_back(mk("slt_5_m50",  3'd5, 32'd5,        32'hFFFF_FFCE, 32'd0,        1, 0));
    vecs.push_back(mk("slt_ovf",    3'd5, 32'h8000_0000, 32'd1,       32'd1,         0, 0));
    vecs.push_back(mk("sltu",       3'd7, 32'hFFFF_FFCE, 32'd5,       32'd0,         1, 0));
    vecs.push_back(mk("add_ovf_p",  3'd0, 32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 0, 1));
    vecs.push_back(mk("add_ovf_n",  3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 1));
    vecs.push_back(mk("sub_ovf",    3'd1, 32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 0, 1));
    vecs.push_back(mk("and_no_ovf", 3'd2, 32'h7FFF_FFFF, 32'd1,       32'd1,         0, 0));
    vecs.push_back(mk("and_no_ovf2",3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0));

    rst = 1'b1; bif.A = 32'hFFFF_FFFF; bif.B = 32'd1; bif.ALUControl = 3'd0;

    step(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1);
    check("reset_c1", 32'd0, 1'b1, 1'b0);
    step(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1);
    check("reset_c2", 32'd0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1);
    check("first_op_wraps_to_zero", 32'd0, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].ov);
    end

    // Back-to-back ADD, SUB, SLT; outputs must hold while the next inputs settle.
    step(1'b0, 3'd0, 32'd100, 32'd23);
    check("b2b_add", 32'd123, 1'b0, 1'b0);
    @(negedge clk);
    bif.ALUControl = 3'd1; bif.A = 32'd7; bif.B = 32'd9;
    #1 check("b2b_hold_add", 32'd123, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("b2b_sub", 32'hFFFF_FFFE, 1'b0, 1'b0);
    step(1'b0, 3'd5, 32'd7, 32'd9);
    check("b2b_slt", 32'd1, 1'b0, 1'b0);

    // Reset during an overflowing ADD: its result must never surface.
    step(1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1);
    check("mid_reset", 32'd0, 1'b1, 1'b0);
    step(1'b0, 3'd3, 32'h0F00, 32'h00F0);
    check("after_mid_reset", 32'h0FF0, 1'b0, 1'b0);

    // Randomized ops with occasional reset.
    for (int n = 0; n < 400; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      if ($urandom_range(0, 24) == 0) begin
        step(1'b1, op, a, b);
        check("rand_reset", 32'd0, 1'b1, 1'b0);
      end else begin
        step(1'b0, op, a, b);
        model(op, a, b, er, ez, eo);
        check($sformatf("rand op=%0d a=%h b=%h", op, a, b), er, ez, eo);
      end
    end

    // Model spot-checks against hand-derived values keep the reference honest.
    model(3'd5, 32'h8000_0000, 32'd1, pr, pz, po);
    checks++;
    if (pr !== 32'd1 || po !== 1'b0) begin
      errors++;
      $display("FAIL model_slt: got %h/%b, expected 00000001/0", pr, po);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
